// File: rtl/imem_responder.sv
// imem_responder
//   Instruction-memory fetch responder with a single outstanding request.
//   A request is accepted in IDLE, the word (or an error NOP) is captured at
//   the acceptance edge, and the response is presented LATENCY cycles later
//   and held until the consumer takes it. A flush discards an in-flight
//   fetch. A separate load port writes program words into storage at any
//   time, including while reset is asserted.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   req_valid/req_ready   fetch request handshake
//   req_addr[31:0]        fetch byte address (PC)
//   flush                 redirect: kill in-flight fetch, block acceptance
//   resp_valid/resp_ready response handshake
//   resp_instr[31:0]      fetched instruction (NOP_WORD on error)
//   resp_addr[31:0]       byte address of the response
//   resp_err              misaligned or out-of-range request
//   ld_en, ld_addr, ld_data  program-load write port
module imem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 2,
  parameter logic [31:0] NOP_WORD    = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        flush,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_instr,
  output logic [31:0] resp_addr,
  output logic        resp_err,
  input  logic        ld_en,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data
);

  localparam int          IDX_W  = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);
  localparam logic [31:0] DEPTH  = 32'(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] mem [DEPTH_WORDS];

  // Fetch result captured at acceptance, published to the outputs on RESP entry
  logic [31:0] pend_instr;
  logic [31:0] pend_addr;
  logic        pend_err;

  logic        accept;
  logic        req_err;
  logic [31:0] req_word;
  logic        ld_in_range;
  logic        unused_ld_lsb;

  // Load address bits [1:0] carry no information for word writes
  assign unused_ld_lsb = ^ld_addr[1:0];

  assign req_ready   = (state == IDLE) && !flush && !reset;
  assign accept      = req_valid && req_ready;
  assign req_err     = (req_addr[1:0] != 2'b00) || ({2'b00, req_addr[31:2]} >= DEPTH);
  // Storage read is only meaningful for in-range aligned requests
  assign req_word    = req_err ? NOP_WORD : mem[req_addr[IDX_W+1:2]];
  assign ld_in_range = {2'b00, ld_addr[31:2]} < DEPTH;

  // Program storage: never reset, writable in every state
  always_ff @(posedge clk) begin
    if (ld_en && ld_in_range) begin
      mem[ld_addr[IDX_W+1:2]] <= ld_data;
    end
  end

  // Acceptance capture: reads the pre-edge storage word, so a same-edge
  // load of the same word returns the old contents
  always_ff @(posedge clk) begin
    if (accept) begin
      pend_instr <= req_word;
      pend_addr  <= req_addr;
      pend_err   <= req_err;
    end
  end

  // Control FSM with registered response outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      resp_valid <= 1'b0;
      resp_instr <= NOP_WORD;
      resp_addr  <= 32'd0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (LATENCY <= 1) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_instr <= req_word;
              resp_addr  <= req_addr;
              resp_err   <= req_err;
            end else begin
              state <= WAIT;
              cnt   <= LAT_M1;
            end
          end
        end
        WAIT: begin
          if (flush) begin
            state <= IDLE;
            cnt   <= 4'd0;
          end else if (cnt <= 4'd1) begin
            // Counter reaches zero on this edge: publish the response
            state      <= RESP;
            cnt        <= 4'd0;
            resp_valid <= 1'b1;
            resp_instr <= pend_instr;
            resp_addr  <= pend_addr;
            resp_err   <= pend_err;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          // A handshake completes even when flush arrives in the same cycle;
          // either way the response is retired and the fetch slot is free
          if (resp_ready || flush) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          cnt        <= 4'd0;
          resp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// tb_imem_responder
//   Self-checking bench for imem_responder (DEPTH_WORDS=1024, LATENCY=2).
//   A behavioural storage array and address rules predict every response.
module tb_imem_responder;

  localparam int          LAT   = 2;
  localparam int          DEPTH = 1024;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        flush;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_instr;
  logic [31:0] resp_addr;
  logic        resp_err;
  logic        ld_en;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;

  int vectors;
  int miscompares;
  int cyc;

  logic [31:0] model_mem [DEPTH];

  imem_responder #(
    .DEPTH_WORDS(DEPTH),
    .LATENCY    (LAT),
    .NOP_WORD   (NOP)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .flush     (flush),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_instr(resp_instr),
    .resp_addr (resp_addr),
    .resp_err  (resp_err),
    .ld_en     (ld_en),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: what a fetch of byte address a must return
  task automatic ref_fetch(input logic [31:0] a, output logic [31:0] instr, output logic err);
    err = (a[1:0] != 2'b00) || (a[31:2] >= 30'(DEPTH));
    if (err) instr = NOP;
    else     instr = model_mem[a[31:2]];
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_load(input logic [31:0] a, input logic [31:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    tick();
    ld_en = 1'b0;
    if (a[31:2] < 30'(DEPTH)) model_mem[a[31:2]] = d;
  endtask

  // Drives one full fetch; hold = cycles of resp_ready=0 before the handshake
  task automatic do_fetch(input logic [31:0] a, input int hold, output logic acc,
                          output int lat, output logic [31:0] o_instr, output logic [31:0] o_addr,
                          output logic o_err, output logic got, output int acc_cyc);
    req_valid = 1'b1; req_addr = a;
    #1 acc = req_ready;
    tick();
    req_valid = 1'b0;
    acc_cyc = cyc;
    lat = 1;
    while (!resp_valid && lat < 40) begin
      tick();
      lat++;
    end
    got = resp_valid;
    o_instr = resp_instr; o_addr = resp_addr; o_err = resp_err;
    if (got) begin
      repeat (hold) tick();
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b1; req_addr = 32'h0; flush = 1'b0; resp_ready = 1'b0;
    ld_en = 1'b1; ld_addr = 32'h0; ld_data = 32'h0050_0093;
    tick();
    model_mem[0] = 32'h0050_0093;
    ld_en = 1'b0;
    tick();
    vectors++; if (req_ready !== 1'b0) begin miscompares++; $display("FAIL reset_req_ready got %0b exp 0", req_ready); end
    vectors++; if (resp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_resp_valid got %0b exp 0", resp_valid); end
    vectors++; if (resp_instr !== NOP) begin miscompares++; $display("FAIL reset_resp_instr got %h exp %h", resp_instr, NOP); end
    vectors++; if (resp_addr !== 32'h0) begin miscompares++; $display("FAIL reset_resp_addr got %h exp 0", resp_addr); end
    vectors++; if (resp_err !== 1'b0) begin miscompares++; $display("FAIL reset_resp_err got %0b exp 0", resp_err); end
    reset = 1'b0; req_valid = 1'b0;
    #1;
    vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL post_reset_req_ready got %0b exp 1", req_ready); end
  endtask

  task automatic test_basic();
    logic acc, err, got; int lat, ac; logic [31:0] ins, ad;
    do_fetch(32'h0, 0, acc, lat, ins, ad, err, got, ac);
    vectors++; if (acc !== 1'b1) begin miscompares++; $display("FAIL basic_accept got %0b exp 1", acc); end
    vectors++; if (lat !== LAT) begin miscompares++; $display("FAIL basic_latency got %0d exp %0d", lat, LAT); end
    vectors++; if (ins !== 32'h0050_0093) begin miscompares++; $display("FAIL basic_instr got %h exp 00500093", ins); end
    vectors++; if (ad !== 32'h0) begin miscompares++; $display("FAIL basic_addr got %h exp 0", ad); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL basic_err got %0b exp 0", err); end
    vectors++; if (resp_valid !== 1'b0) begin miscompares++; $display("FAIL basic_valid_drop got %0b exp 0", resp_valid); end
    vectors++; if (resp_instr !== 32'h0050_0093) begin miscompares++; $display("FAIL basic_instr_retain got %h exp 00500093", resp_instr); end
  endtask

  task automatic test_preload();
    for (int w = 1; w < 64; w++) do_load(32'(w) << 2, $urandom);
    do_load(32'h10, 32'h1111_1111);
    do_load(32'hFFC, 32'hCAFE_F00D);
    do_load(32'h1000, 32'hBAD0_BAD0);
  endtask

  task automatic test_random();
    logic acc, err, got, e_err; int lat, ac; logic [31:0] ins, ad, a, e_ins; int r;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 2) == 0) do_load(32'($urandom_range(0, 63)) << 2, $urandom);
      r = $urandom_range(0, 9);
      if (r < 6)      a = 32'($urandom_range(0, 63)) << 2;
      else if (r < 8) a = (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(1, 3));
      else            a = $urandom | 32'h0000_1000;
      ref_fetch(a, e_ins, e_err);
      do_fetch(a, $urandom_range(0, 3), acc, lat, ins, ad, err, got, ac);
      vectors++;
      if (!got || lat !== LAT || ins !== e_ins || ad !== a || err !== e_err) begin
        miscompares++;
        $display("FAIL random_fetch addr %h got v=%0b lat=%0d instr=%h addr=%h err=%0b exp lat=%0d instr=%h err=%0b",
                 a, got, lat, ins, ad, err, LAT, e_ins, e_err);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] ins, ad; logic err; int t;
    req_valid = 1'b1; req_addr = 32'h4;
    tick();
    req_valid = 1'b0;
    t = 0;
    while (!resp_valid && t < 40) begin tick(); t++; end
    vectors++; if (resp_valid !== 1'b1) begin miscompares++; $display("FAIL bp_response got %0b exp 1", resp_valid); end
    ins = resp_instr; ad = resp_addr; err = resp_err;
    vectors++; if (ins !== model_mem[1]) begin miscompares++; $display("FAIL bp_instr got %h exp %h", ins, model_mem[1]); end
    for (int k = 0; k < 5; k++) begin
      tick();
      vectors++;
      if (resp_valid !== 1'b1 || resp_instr !== ins || resp_addr !== 32'h4 || resp_err !== 1'b0 || req_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_hold cycle %0d got v=%0b instr=%h addr=%h err=%0b rdy=%0b exp v=1 instr=%h addr=4 err=0 rdy=0",
                 k, resp_valid, resp_instr, resp_addr, resp_err, req_ready, ins);
      end
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    vectors++; if (resp_valid !== 1'b0) begin miscompares++; $display("FAIL bp_release_valid got %0b exp 0", resp_valid); end
    vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL bp_release_ready got %0b exp 1", req_ready); end
  endtask

  task automatic test_errors();
    logic acc, err, got; int lat, ac; logic [31:0] ins, ad;
    do_fetch(32'h2, 0, acc, lat, ins, ad, err, got, ac);
    vectors++; if (!got || err !== 1'b1 || ins !== NOP || ad !== 32'h2) begin miscompares++; $display("FAIL err_misaligned got err=%0b instr=%h addr=%h exp err=1 instr=%h addr=2", err, ins, ad, NOP); end
    do_fetch(32'h1000, 1, acc, lat, ins, ad, err, got, ac);
    vectors++; if (!got || err !== 1'b1 || ins !== NOP || ad !== 32'h1000) begin miscompares++; $display("FAIL err_range got err=%0b instr=%h addr=%h exp err=1 instr=%h addr=1000", err, ins, ad, NOP); end
    do_fetch(32'hFFC, 0, acc, lat, ins, ad, err, got, ac);
    vectors++; if (!got || err !== 1'b0 || ins !== 32'hCAFE_F00D) begin miscompares++; $display("FAIL err_last_word got err=%0b instr=%h exp err=0 instr=cafef00d", err, ins); end
  endtask

  task automatic test_flush();
    logic acc, err, got, seen; int lat, ac, t; logic [31:0] ins, ad;
    // flush in IDLE blocks acceptance
    flush = 1'b1; req_valid = 1'b1; req_addr = 32'h0;
    #1;
    vectors++; if (req_ready !== 1'b0) begin miscompares++; $display("FAIL flush_idle_ready got %0b exp 0", req_ready); end
    tick();
    flush = 1'b0; req_valid = 1'b0;
    seen = 1'b0;
    repeat (LAT + 2) begin if (resp_valid) seen = 1'b1; tick(); end
    vectors++; if (seen !== 1'b0) begin miscompares++; $display("FAIL flush_idle_noresp got %0b exp 0", seen); end
    // flush in WAIT
    req_valid = 1'b1; req_addr = 32'h4;
    tick();
    req_valid = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    seen = 1'b0;
    repeat (LAT + 2) begin if (resp_valid) seen = 1'b1; tick(); end
    vectors++; if (seen !== 1'b0) begin miscompares++; $display("FAIL flush_wait_noresp got %0b exp 0", seen); end
    vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL flush_wait_ready got %0b exp 1", req_ready); end
    do_fetch(32'h8, 0, acc, lat, ins, ad, err, got, ac);
    vectors++; if (!got || lat !== LAT || ins !== model_mem[2] || ad !== 32'h8) begin miscompares++; $display("FAIL flush_refetch got lat=%0d instr=%h addr=%h exp lat=%0d instr=%h addr=8", lat, ins, ad, LAT, model_mem[2]); end
    // flush in RESP
    req_valid = 1'b1; req_addr = 32'hC;
    tick();
    req_valid = 1'b0;
    t = 0;
    while (!resp_valid && t < 40) begin tick(); t++; end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    seen = 1'b0;
    repeat (LAT + 2) begin if (resp_valid) seen = 1'b1; tick(); end
    vectors++; if (seen !== 1'b0) begin miscompares++; $display("FAIL flush_resp_noresp got %0b exp 0", seen); end
  endtask

  task automatic test_reset_mid_resp();
    logic acc, err, got; int lat, ac, t; logic [31:0] ins, ad;
    req_valid = 1'b1; req_addr = 32'h8;
    tick();
    req_valid = 1'b0;
    t = 0;
    while (!resp_valid && t < 40) begin tick(); t++; end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    vectors++; if (resp_valid !== 1'b0 || req_ready !== 1'b1 || resp_instr !== NOP || resp_addr !== 32'h0) begin
      miscompares++; $display("FAIL reset_mid_resp got v=%0b rdy=%0b instr=%h addr=%h exp v=0 rdy=1 instr=%h addr=0", resp_valid, req_ready, resp_instr, resp_addr, NOP);
    end
    do_fetch(32'h8, 0, acc, lat, ins, ad, err, got, ac);
    vectors++; if (!got || ins !== model_mem[2]) begin miscompares++; $display("FAIL reset_storage got %h exp %h", ins, model_mem[2]); end
  endtask

  task automatic test_load_collisions();
    logic acc, err, got; int lat, ac, t; logic [31:0] ins, ad, old;
    // same-edge load and accept of word 4
    req_valid = 1'b1; req_addr = 32'h10;
    ld_en = 1'b1; ld_addr = 32'h10; ld_data = 32'hDEAD_BEEF;
    tick();
    req_valid = 1'b0; ld_en = 1'b0;
    t = 0;
    while (!resp_valid && t < 40) begin tick(); t++; end
    vectors++; if (resp_valid !== 1'b1 || resp_instr !== 32'h1111_1111) begin miscompares++; $display("FAIL same_edge_old got %h exp 11111111", resp_instr); end
    model_mem[4] = 32'hDEAD_BEEF;
    resp_ready = 1'b1; tick(); resp_ready = 1'b0;
    do_fetch(32'h10, 0, acc, lat, ins, ad, err, got, ac);
    vectors++; if (!got || ins !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL same_edge_new got %h exp deadbeef", ins); end
    // load during WAIT does not disturb the in-flight word
    old = model_mem[5];
    req_valid = 1'b1; req_addr = 32'h14;
    tick();
    req_valid = 1'b0;
    ld_en = 1'b1; ld_addr = 32'h14; ld_data = ~old;
    tick();
    ld_en = 1'b0; model_mem[5] = ~old;
    t = 0;
    while (!resp_valid && t < 40) begin tick(); t++; end
    vectors++; if (resp_valid !== 1'b1 || resp_instr !== old) begin miscompares++; $display("FAIL inflight_load got %h exp %h", resp_instr, old); end
    resp_ready = 1'b1; tick(); resp_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic acc, err, got; int lat, ac, prev; logic [31:0] ins, ad;
    do_fetch(32'h0, 0, acc, lat, ins, ad, err, got, prev);
    for (int k = 1; k < 5; k++) begin
      do_fetch(32'(k) << 2, 0, acc, lat, ins, ad, err, got, ac);
      vectors++; if (!acc || ac - prev !== LAT + 1 || ins !== model_mem[k]) begin
        miscompares++; $display("FAIL back_to_back %0d got spacing=%0d instr=%h exp spacing=%0d instr=%h", k, ac - prev, ins, LAT + 1, model_mem[k]);
      end
      prev = ac;
    end
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    for (int w = 0; w < DEPTH; w++) model_mem[w] = 32'h0;
    reset = 1'b1; req_valid = 1'b0; req_addr = 32'h0; flush = 1'b0; resp_ready = 1'b0;
    ld_en = 1'b0; ld_addr = 32'h0; ld_data = 32'h0;
    #1;
    test_reset();
    test_basic();
    test_preload();
    test_backpressure();
    test_errors();
    test_flush();
    test_reset_mid_resp();
    test_load_collisions();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout got timeout exp completion");
    $fatal(1, "bench timeout");
  end

endmodule

// File: doc/imem_responder.md
IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024: instruction storage depth in 32-bit words (power of two, >=2).
REQ-002 Parameter LATENCY, default 2: cycles from request acceptance to first resp_valid (legal range 1..15).
REQ-003 Parameter NOP_WORD, default 32'h00000013: instruction returned on error responses.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req_valid  input  1  fetch request present.
REQ-007 req_ready  output  1  responder can accept a request this cycle.
REQ-008 req_addr  input  32  byte address of instruction (program counter value).
REQ-009 flush  input  1  redirect; kill any in-flight fetch.
REQ-010 resp_valid  output  1  response present.
REQ-011 resp_ready  input  1  consumer accepts response this cycle.
REQ-012 resp_instr  output  32  fetched instruction word.
REQ-013 resp_addr  output  32  byte address the response belongs to.
REQ-014 resp_err  output  1  request was misaligned or out of range.
REQ-015 ld_en  input  1  program-load write strobe.
REQ-016 ld_addr  input  32  load byte address (word aligned; bits [1:0] ignored).
REQ-017 ld_data  input  32  load data word.

Function
REQ-018 FSM states IDLE, WAIT, RESP; req_ready SHALL be 1 only in IDLE with flush=0.
REQ-019 Accept = req_valid & req_ready at a rising edge; captures req_addr, storage word, error status.
REQ-020 Error: req_addr[1:0]!=0 or word index req_addr[31:2] >= DEPTH_WORDS; then resp_err=1, resp_instr=NOP_WORD.
REQ-021 Non-error: resp_instr = storage[req_addr[31:2]] as of the acceptance edge; resp_err=0.
REQ-022 Accept at edge E: LATENCY=1 -> RESP after E; LATENCY>1 -> WAIT with counter LATENCY-1, decrement each edge, enter RESP on the edge where the counter reaches 0; resp_valid first high exactly LATENCY cycles after E.
REQ-023 In RESP, resp_valid=1 and resp_instr/resp_addr/resp_err SHALL hold stable until resp_valid & resp_ready; then IDLE.
REQ-024 Outside RESP, resp_valid=0; resp_instr/resp_addr/resp_err retain last values.
REQ-025 Maximum one outstanding request; after a response handshake the next acceptance is no earlier than the following cycle (throughput one per LATENCY+1 cycles).
REQ-026 flush=1 in WAIT or RESP SHALL discard the fetch and return to IDLE at the next edge; no response for it is ever presented.
REQ-027 flush=1 in IDLE SHALL block acceptance that cycle (req_ready=0).
REQ-028 flush and resp_valid&resp_ready in the same RESP cycle: handshake completes, then IDLE.
REQ-029 ld_en=1 writes ld_data to storage[ld_addr[31:2]] at the edge if index < DEPTH_WORDS, else ignored; any state.
REQ-030 Load and acceptance of the same word on the same edge: response returns the old word.
REQ-031 Loads after acceptance do not alter the in-flight response.

Reset
REQ-032 reset=1 at an edge: state IDLE, counter 0, resp_valid=0, resp_instr=NOP_WORD, resp_addr=0, resp_err=0; overrides flush, request, and in-flight fetch.
REQ-033 Storage contents are not cleared by reset; ld_en is honoured while reset=1.
REQ-034 req_ready=0 during any cycle with reset=1.

Verification
REQ-035 LATENCY=2: load 0x00500093 at addr 0x0; request 0x0 at edge E, resp_ready=1 -> resp_valid high at E+2 only, instr 0x00500093, addr 0x0, err 0.
REQ-036 Backpressure: resp_ready=0 for 5 cycles in RESP -> resp_valid and outputs stable 5 cycles; req_ready=0 throughout; handshake on 6th -> IDLE.
REQ-037 Errors: request 0x2 -> err=1, instr 0x00000013; DEPTH_WORDS=1024, request 0x1000 -> err=1, addr 0x1000.
REQ-038 Flush in WAIT (1 cycle after accept of 0x4) -> no resp_valid; next request 0x8 returns storage[2] after LATENCY.
REQ-039 Reset mid-RESP with resp_valid=1 -> next cycle resp_valid=0, req_ready=1, resp_instr=0x00000013; storage intact.
REQ-040 Same-edge load of 0xDEADBEEF to 0x10 and accept 0x10 (old 0x11111111) -> response 0x11111111; re-fetch returns 0xDEADBEEF.
